product_accumulator: RTL

//  Downstream stage of the 4x4 gate-level multiplier. Consumes its 8-bit products (bit 0 = LSB)

---
 rtl/mult_pkg.sv | 17 +
 rtl/product_accumulator_sat_adder.sv | 22 ++
 rtl/product_accumulator.sv | 92 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / product accumulator datapath.
package mult_pkg;

  localparam int unsigned PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Width needed to hold a count from 0 up to and including len.
  function automatic int unsigned cnt_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Combinational saturating adder: ACC_W-bit accumulator plus an unsigned 8-bit product.
module sat_adder
  import mult_pkg::*;
#(
  parameter int unsigned ACC_W = 16
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  logic [ACC_W:0] wide;

  // Add one bit wider than the accumulator; the carry-out marks saturation.
  always_comb begin
    wide = {1'b0, a} + (ACC_W + 1)'(b);
    sat  = wide[ACC_W];
    sum  = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums LEN consecutive multiplier products into a saturating ACC_W-bit result and
// presents it on a held valid/ready port.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned LEN   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic [PROD_W-1:0]           prod_in,
  input  logic                        prod_valid,
  output logic                        prod_ready,
  output logic [ACC_W-1:0]            sum_out,
  output logic                        sum_valid,
  input  logic                        sum_ready,
  output logic                        overflow,
  output logic [cnt_width(LEN)-1:0]   count
);

  localparam int unsigned CW = cnt_width(LEN);
  localparam logic [CW-1:0] LEN_C = CW'(LEN);

  state_t         state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] add_sum;
  logic           add_sat;
  logic [CW-1:0]  count_nxt;
  logic           accept;
  logic           handoff;

  sat_adder #(
    .ACC_W(ACC_W)
  ) u_sat_adder (
    .a  (acc_q),
    .b  (prod_in),
    .sum(add_sum),
    .sat(add_sat)
  );

  // clear and rst both block acceptance so no product slips in during an abort.
  assign prod_ready = ~rst & ~clear & (state_q != HOLD);
  assign accept     = prod_valid & prod_ready;
  assign sum_valid  = (state_q == HOLD);
  assign handoff    = sum_valid & sum_ready;
  assign sum_out    = acc_q;
  assign count_nxt  = count + CW'(1);

  // FSM with accumulator, term counter and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q    <= ACC_W'(prod_in);
            count    <= CW'(1);
            overflow <= 1'b0;
            state_q  <= (LEN == 1) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_q    <= add_sum;
            overflow <= overflow | add_sat;
            count    <= count_nxt;
            if (count_nxt == LEN_C) state_q <= HOLD;
          end
        end
        HOLD: begin
          // acc keeps the delivered value; only sum_valid qualifies it.
          if (handoff) begin
            state_q <= IDLE;
            count   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
